median_blur_stream_ctrl: RTL and testbench

//   Streaming controller for the combinational 3x3 median core (9x8-bit in, 8-bit median out).

---
 rtl/median_blur_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_median_blur_stream_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_blur_stream_ctrl.sv
// -----------------------------------------------------------------------------
// median_blur_stream_ctrl
//   Streaming 3x3 median filter controller. Accepts one raster-order frame of
//   IMG_W x IMG_H 8-bit pixels, keeps two line buffers and a sliding 3x3
//   window, feeds a combinational 3x3 median core, and emits the
//   (IMG_W-2)x(IMG_H-2) interior medians through a registered valid/ready
//   output stage.
//
// Ports
//   clk        in   1  single clock, all state on rising edge
//   rst_n      in   1  synchronous reset, active-low
//   start      in   1  one-cycle pulse; begins a frame when idle
//   in_pixel   in   8  input pixel, raster order
//   in_valid   in   1  in_pixel valid
//   in_ready   out  1  controller can accept in_pixel
//   out_pixel  out  8  median of the window centred at (r-1,c-1)
//   out_valid  out  1  out_pixel valid
//   out_ready  in   1  sink accepts out_pixel
//   out_last   out  1  marks the last interior output of the frame
//   busy       out  1  controller is not idle
//   frame_done out  1  one-cycle pulse after the last output handshake
// -----------------------------------------------------------------------------

// Combinational 3x3 median: px_1..px_9 is the window in row-major order.
module median3x3_core (
    input  logic [7:0] px_1,
    input  logic [7:0] px_2,
    input  logic [7:0] px_3,
    input  logic [7:0] px_4,
    input  logic [7:0] px_5,
    input  logic [7:0] px_6,
    input  logic [7:0] px_7,
    input  logic [7:0] px_8,
    input  logic [7:0] px_9,
    output logic [7:0] median
);

    // Full bubble sort of nine values; the median is the middle element.
    function automatic logic [7:0] f_median9(input logic [71:0] i_flat);
        logic [7:0] v [9];
        logic [7:0] t;
        t = '0;
        for (int k = 0; k < 9; k++) begin
            v[k] = i_flat[8*k +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t      = v[j];
                    v[j]   = v[j+1];
                    v[j+1] = t;
                end
            end
        end
        return v[4];
    endfunction

    assign median = f_median9({px_9, px_8, px_7, px_6, px_5, px_4, px_3, px_2, px_1});

endmodule

module median_blur_stream_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_pixel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;

    // Line buffer 0 holds row r-1, line buffer 1 holds row r-2 (at column c).
    logic [7:0]     r_lb0 [IMG_W];
    logic [7:0]     r_lb1 [IMG_W];

    logic [7:0]     w_new_col [3];
    logic           w_accept;
    logic           w_load;
    logic           w_col_end;
    logic           w_last_px;
    logic           w_drain_exit;
    logic [7:0]     w_median;

    logic [7:0]     r_out_pixel;
    logic           r_out_valid;
    logic           r_out_last;
    logic           r_frame_done;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    // A pending output that the sink refuses blocks new pixels, so the
    // output register can never be overwritten before it is consumed.
    assign in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != S_IDLE);

    assign w_col_end = (r_col == COL_LAST);
    assign w_last_px = (r_row == ROW_LAST) && w_col_end;
    // Columns 0/1 of each row would mix stale pixels of the previous row
    // into the window; only positions with a full 3x3 history produce output.
    assign w_load    = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : state_next
        w_state_next = r_state;
        w_drain_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_last_px) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_out_valid || out_ready) begin
                    w_state_next = S_IDLE;
                    w_drain_exit = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : position_counters
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers (contents need no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : line_buffers
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= in_pixel;
        end
    end

    // Incoming right-hand column, top to bottom.
    assign w_new_col[0] = r_lb1[r_col];
    assign w_new_col[1] = r_lb0[r_col];
    assign w_new_col[2] = in_pixel;

    // ------------------------------------------------------------------
    // Sliding window
    // The core is fed the window as it looks after the accept-time shift:
    // the current middle and right columns plus the incoming column. That
    // gives a one-cycle accept-to-output latency and means the oldest
    // (left) column never has to be stored.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            logic [7:0] r_win_mid;
            logic [7:0] r_win_right;

            always_ff @(posedge clk) begin : window_shift
                if (w_accept) begin
                    r_win_mid   <= r_win_right;
                    r_win_right <= w_new_col[gi];
                end
            end
        end
    endgenerate

    median3x3_core u_core (
        .px_1   (g_win_row[0].r_win_mid),
        .px_2   (g_win_row[0].r_win_right),
        .px_3   (w_new_col[0]),
        .px_4   (g_win_row[1].r_win_mid),
        .px_5   (g_win_row[1].r_win_right),
        .px_6   (w_new_col[1]),
        .px_7   (g_win_row[2].r_win_mid),
        .px_8   (g_win_row[2].r_win_right),
        .px_9   (w_new_col[2]),
        .median (w_median)
    );

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : output_reg
        if (!rst_n) begin
            r_out_pixel <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_pixel <= w_median;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_px;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : done_reg
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_drain_exit;
        end
    end

    assign out_pixel  = r_out_pixel;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_median_blur_stream_ctrl.sv
module tb_median_blur_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8x8 instance
    logic       rst_n8, start8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic       out_last8, busy8, frame_done8;
    logic [7:0] in_pixel8, out_pixel8;

    // 3x3 instance
    logic       rst_n3, start3, in_valid3, in_ready3, out_valid3, out_ready3;
    logic       out_last3, busy3, frame_done3;
    logic [7:0] in_pixel3, out_pixel3;

    median_blur_stream_ctrl #(.IMG_W(8), .IMG_H(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8),
        .in_pixel(in_pixel8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_pixel(out_pixel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_last(out_last8), .busy(busy8), .frame_done(frame_done8)
    );

    median_blur_stream_ctrl #(.IMG_W(3), .IMG_H(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .start(start3),
        .in_pixel(in_pixel3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_pixel(out_pixel3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_last(out_last3), .busy(busy3), .frame_done(frame_done3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    // ------------------------------------------------------------------
    // Reference model: whole frame in an array, medians by rank counting
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    logic [7:0] frm [64];
    exp_t       exp_q [$];

    function automatic logic [7:0] ref_median(input logic [7:0] v [9]);
        logic [7:0] res;
        int lt, le;
        res = '0;
        for (int k = 0; k < 9; k++) begin
            lt = 0; le = 0;
            for (int m = 0; m < 9; m++) begin
                if (v[m] <  v[k]) lt++;
                if (v[m] <= v[k]) le++;
            end
            if (lt <= 4 && le >= 5) res = v[k];
        end
        return res;
    endfunction

    task automatic build_expected();
        logic [7:0] v [9];
        exp_t e;
        exp_q.delete();
        for (int i = 1; i <= 6; i++) begin
            for (int j = 1; j <= 6; j++) begin
                for (int k = 0; k < 9; k++) v[k] = frm[(i - 1 + k / 3) * 8 + (j - 1 + k % 3)];
                e.pix  = ref_median(v);
                e.last = (i == 6 && j == 6);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int p = 0; p < 64; p++) frm[p] = 8'(p);
    endtask

    task automatic fill_impulse();
        for (int p = 0; p < 64; p++) frm[p] = 8'd0;
        frm[3 * 8 + 3] = 8'd255;
    endtask

    task automatic fill_random();
        for (int p = 0; p < 64; p++) frm[p] = 8'($urandom_range(0, 255));
    endtask

    // ------------------------------------------------------------------
    // Output monitor for the 8x8 instance (samples on the falling edge)
    // ------------------------------------------------------------------
    int done_cnt = 0;
    int n_out    = 0;

    initial begin : monitor
        logic       prev_stall, done_pending, prev_last;
        logic [7:0] prev_pix;
        exp_t       e;
        prev_stall = 1'b0; done_pending = 1'b0; prev_last = 1'b0; prev_pix = '0;
        forever begin
            @(negedge clk);
            if (rst_n8 !== 1'b1) begin
                prev_stall   = 1'b0;
                done_pending = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 32'(out_valid8), 32'(1'b1));
                    check("stall_hold_pixel", 32'(out_pixel8), 32'(prev_pix));
                    check("stall_hold_last", 32'(out_last8), 32'(prev_last));
                end
                if (out_valid8 && !out_ready8)
                    check("bp_in_ready", 32'(in_ready8), 32'(1'b0));
                if (frame_done8 || done_pending) begin
                    check("frame_done", 32'(frame_done8), 32'(done_pending));
                    if (done_pending) check("busy_at_done", 32'(busy8), 32'(1'b0));
                end
                if (frame_done8) done_cnt++;
                done_pending = out_valid8 && out_ready8 && out_last8;
                if (out_valid8 && out_ready8) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL out_extra: got pixel %0d, required no output", out_pixel8);
                    end else begin
                        e = exp_q.pop_front();
                        $display("out #%0d pix=%0d last=%0d (model %0d/%0d)",
                                 n_out, out_pixel8, out_last8, e.pix, e.last);
                        check("out_pixel", 32'(out_pixel8), 32'(e.pix));
                        check("out_last", 32'(out_last8), 32'(e.last));
                    end
                end
                prev_stall = out_valid8 && !out_ready8;
                prev_pix   = out_pixel8;
                prev_last  = out_last8;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame driver for the 8x8 instance; entered and left just after a
    // rising edge. gap_mode: 0 none, 1 every third cycle idle, 2 random.
    // ------------------------------------------------------------------
    task automatic run_frame(input int gap_mode, input bit rand_rdy, input bit mid_start,
                             input int abort_at);
        int idx, cyc, d0;
        bit acc;
        build_expected();
        d0 = done_cnt;
        start8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 64 && cyc < 3000) begin
            case (gap_mode)
                0:       in_valid8 = 1'b1;
                1:       in_valid8 = (cyc % 3 != 2);
                default: in_valid8 = ($urandom_range(0, 3) != 0);
            endcase
            in_pixel8  = frm[idx];
            out_ready8 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start8     = mid_start && (idx == 30);
            @(negedge clk);
            acc = in_valid8 && in_ready8;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (abort_at != 0 && idx == abort_at) break;
        end
        in_valid8 = 1'b0; start8 = 1'b0;
        if (abort_at != 0) begin
            check("abort_reached", 32'(idx), 32'(abort_at));
            rst_n8 = 1'b0; out_ready8 = 1'b1;
            @(posedge clk); #1;
            rst_n8 = 1'b1;
            @(negedge clk);
            check("abort_out_valid", 32'(out_valid8), 32'(1'b0));
            check("abort_busy", 32'(busy8), 32'(1'b0));
            check("abort_in_ready", 32'(in_ready8), 32'(1'b0));
            check("abort_frame_done", 32'(frame_done8), 32'(1'b0));
            check("abort_out_pixel", 32'(out_pixel8), 32'(8'd0));
            check("abort_out_last", 32'(out_last8), 32'(1'b0));
            exp_q.delete();
            @(posedge clk); #1;
            return;
        end
        check("pixels_accepted", 32'(idx), 32'(64));
        while (done_cnt == d0 && cyc < 3000) begin
            out_ready8 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        check("frame_done_count", 32'(done_cnt - d0), 32'(1));
        check("outputs_left", 32'(exp_q.size()), 32'(0));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Cycle table for the 3x3 instance: pixels 9,1,8,2,7,3,6,4,5
    // ------------------------------------------------------------------
    typedef struct {
        logic       start;
        logic       iv;
        logic [7:0] px;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_op;
        logic       e_ol;
        logic       e_busy;
        logic       e_fd;
    } vec_t;

    vec_t tbl [16];

    initial begin : main
        tbl[0]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}; // start
        tbl[1]  = '{1'b0, 1'b1, 8'd9,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'd1,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'd8,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'd2,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'd99, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0}; // gap
        tbl[6]  = '{1'b1, 1'b1, 8'd7,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0}; // start ignored
        tbl[7]  = '{1'b0, 1'b1, 8'd3,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'd6,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'd4,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'd5,  1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0}; // 9th accept
        tbl[11] = '{1'b0, 1'b1, 8'd77, 1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0}; // stalled
        tbl[12] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0}; // handshake
        tbl[14] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1}; // done pulse
        tbl[15] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

        rst_n8 = 1'b0; start8 = 1'b0; in_valid8 = 1'b0; in_pixel8 = '0; out_ready8 = 1'b1;
        rst_n3 = 1'b0; start3 = 1'b0; in_valid3 = 1'b0; in_pixel3 = '0; out_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n8 = 1'b1; rst_n3 = 1'b1;
        @(negedge clk);
        check("rst8_out_valid", 32'(out_valid8), 32'(1'b0));
        check("rst8_out_pixel", 32'(out_pixel8), 32'(8'd0));
        check("rst8_out_last", 32'(out_last8), 32'(1'b0));
        check("rst8_busy", 32'(busy8), 32'(1'b0));
        check("rst8_frame_done", 32'(frame_done8), 32'(1'b0));
        check("rst8_in_ready", 32'(in_ready8), 32'(1'b0));
        check("rst3_out_valid", 32'(out_valid3), 32'(1'b0));
        check("rst3_busy", 32'(busy3), 32'(1'b0));
        @(posedge clk); #1;

        // 3x3 frame, one vector per cycle
        for (int k = 0; k < 16; k++) begin
            start3 = tbl[k].start; in_valid3 = tbl[k].iv;
            in_pixel3 = tbl[k].px; out_ready3 = tbl[k].ordy;
            @(negedge clk);
            $display("tbl row %0d: ir=%0d ov=%0d op=%0d ol=%0d busy=%0d fd=%0d",
                     k, in_ready3, out_valid3, out_pixel3, out_last3, busy3, frame_done3);
            check($sformatf("tbl%0d_in_ready", k), 32'(in_ready3), 32'(tbl[k].e_ir));
            check($sformatf("tbl%0d_out_valid", k), 32'(out_valid3), 32'(tbl[k].e_ov));
            check($sformatf("tbl%0d_busy", k), 32'(busy3), 32'(tbl[k].e_busy));
            check($sformatf("tbl%0d_frame_done", k), 32'(frame_done3), 32'(tbl[k].e_fd));
            if (tbl[k].e_ov) begin
                check($sformatf("tbl%0d_out_pixel", k), 32'(out_pixel3), 32'(tbl[k].e_op));
                check($sformatf("tbl%0d_out_last", k), 32'(out_last3), 32'(tbl[k].e_ol));
            end
            @(posedge clk); #1;
        end
        start3 = 1'b0; in_valid3 = 1'b0;

        // 8x8 scenarios
        fill_ramp();    run_frame(0, 1'b0, 1'b0, 0);   // ramp, no stalls
        fill_impulse(); run_frame(0, 1'b0, 1'b0, 0);   // impulse rejected
        fill_ramp();    run_frame(0, 1'b1, 1'b0, 0);   // random backpressure
        fill_ramp();    run_frame(1, 1'b0, 1'b0, 0);   // input gaps
        fill_ramp();    run_frame(0, 1'b0, 1'b1, 0);   // start mid-frame ignored
        fill_ramp();    run_frame(0, 1'b0, 1'b0, 20);  // reset after 20 pixels
        fill_ramp();    run_frame(0, 1'b0, 1'b0, 0);   // fresh frame after abort
        for (int f = 0; f < 3; f++) begin
            fill_random(); run_frame(2, 1'b1, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
